// File: rtl/conv_axi_pkg.sv
// Shared encodings for the conv AXI burst initiator: response/burst codes and FSM states.
package conv_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AW   = 3'd1,
    ST_W    = 3'd2,
    ST_B    = 3'd3,
    ST_AR   = 3'd4,
    ST_R    = 3'd5,
    ST_FIN  = 3'd6
  } state_t;

endpackage

// File: rtl/conv_axi_burst_master.sv
// Single-outstanding AXI4 INCR burst initiator: one command in, one burst out,
// data bridged to/from a valid/ready stream, done pulse with error flag at the end.
//
// state | meaning
// IDLE  | waiting for a command (cmd_ready=1)
// AW    | presenting write address
// W     | streaming write beats from s_w*
// B     | waiting for write response
// AR    | presenting read address
// R     | streaming read beats to m_r*
// FIN   | one-cycle done pulse
module conv_axi_burst_master
  import conv_axi_pkg::*;
#(
  parameter int M_ID_BW   = 10,
  parameter int M_ADDR_BW = 16,
  parameter int M_DATA_BW = 32,
  parameter int M_STRB_BW = M_DATA_BW / 8
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,

  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [M_ADDR_BW-1:0] cmd_addr,
  input  logic [8:0]           cmd_len,
  input  logic [M_ID_BW-1:0]   cmd_id,

  input  logic [M_DATA_BW-1:0] s_wdata,
  input  logic                 s_wvalid,
  output logic                 s_wready,

  output logic [M_DATA_BW-1:0] m_rdata,
  output logic                 m_rvalid,
  input  logic                 m_rready,
  output logic                 m_rlast,

  output logic                 done,
  output logic                 err,

  output logic [M_ID_BW-1:0]   AWID,
  output logic [M_ADDR_BW-1:0] AWADDR,
  output logic [7:0]           AWLEN,
  output logic [2:0]           AWSIZE,
  output logic [1:0]           AWBURST,
  output logic                 AWLOCK,
  output logic [3:0]           AWCACHE,
  output logic [2:0]           AWPROT,
  output logic [3:0]           AWQOS,
  output logic [3:0]           AWREGION,
  output logic                 AWVALID,
  input  logic                 AWREADY,

  output logic [M_DATA_BW-1:0] WDATA,
  output logic [M_STRB_BW-1:0] WSTRB,
  output logic                 WLAST,
  output logic                 WVALID,
  input  logic                 WREADY,

  input  logic [M_ID_BW-1:0]   BID,
  input  logic [2:0]           BRESP,
  input  logic                 BVALID,
  output logic                 BREADY,

  output logic [M_ID_BW-1:0]   ARID,
  output logic [M_ADDR_BW-1:0] ARADDR,
  output logic [7:0]           ARLEN,
  output logic [2:0]           ARSIZE,
  output logic [1:0]           ARBURST,
  output logic                 ARLOCK,
  output logic [3:0]           ARCACHE,
  output logic [2:0]           ARPROT,
  output logic [3:0]           ARQOS,
  output logic [3:0]           ARREGION,
  output logic                 ARVALID,
  input  logic                 ARREADY,

  input  logic [M_ID_BW-1:0]   RID,
  input  logic [M_DATA_BW-1:0] RDATA,
  input  logic [2:0]           RRESP,
  input  logic                 RLAST,
  input  logic                 RVALID,
  output logic                 RREADY
);

  localparam logic [2:0] AX_SIZE = 3'($clog2(M_STRB_BW));

  state_t               state_q, state_d;
  logic [M_ID_BW-1:0]   id_q;
  logic [M_ADDR_BW-1:0] addr_q;
  logic [7:0]           len_m1_q;
  logic [8:0]           cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic                 ready_en_q;
  logic                 load;

  logic last_beat;
  logic w_hs;
  logic r_hs;
  logic r_beat_err;
  logic unused_resp_bits;

  // Upper response bits carry no meaning for this initiator.
  assign unused_resp_bits = ^{BRESP[2], RRESP[2]};

  // Counter never exceeds 255, so a 256-beat burst ends before any wrap.
  assign last_beat  = (cnt_q == {1'b0, len_m1_q});
  assign w_hs       = WVALID & WREADY;
  assign r_hs       = RVALID & RREADY;
  assign r_beat_err = (RID != id_q) || (RRESP[1:0] != RESP_OKAY) || (RLAST != last_beat);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      ready_en_q <= 1'b0;
      id_q       <= '0;
      addr_q     <= '0;
      len_m1_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      ready_en_q <= 1'b1;
      if (load) begin
        id_q     <= cmd_id;
        addr_q   <= cmd_addr;
        len_m1_q <= cmd_len[7:0] - 8'd1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    load      = 1'b0;
    cmd_ready = 1'b0;
    AWVALID   = 1'b0;
    ARVALID   = 1'b0;
    WVALID    = 1'b0;
    WLAST     = 1'b0;
    s_wready  = 1'b0;
    BREADY    = 1'b0;
    RREADY    = 1'b0;
    m_rvalid  = 1'b0;
    m_rlast   = 1'b0;
    done      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cmd_ready = ready_en_q;
        if (cmd_valid && ready_en_q) begin
          load  = 1'b1;
          err_d = 1'b0;
          cnt_d = '0;
          if (cmd_len == 9'd0) begin
            err_d   = 1'b1;
            state_d = ST_FIN;
          end else if (cmd_write) begin
            state_d = ST_AW;
          end else begin
            state_d = ST_AR;
          end
        end
      end
      ST_AW: begin
        AWVALID = 1'b1;
        if (AWREADY) state_d = ST_W;
      end
      ST_W: begin
        WVALID   = s_wvalid;
        WLAST    = last_beat;
        s_wready = WREADY;
        if (w_hs) begin
          if (last_beat) begin
            cnt_d   = '0;
            state_d = ST_B;
          end else begin
            cnt_d = cnt_q + 9'd1;
          end
        end
      end
      ST_B: begin
        BREADY = 1'b1;
        if (BVALID) begin
          err_d   = (BID != id_q) || (BRESP[1:0] != RESP_OKAY);
          state_d = ST_FIN;
        end
      end
      ST_AR: begin
        ARVALID = 1'b1;
        if (ARREADY) state_d = ST_R;
      end
      ST_R: begin
        m_rvalid = RVALID;
        m_rlast  = RLAST;
        RREADY   = m_rready;
        if (r_hs) begin
          if (r_beat_err) err_d = 1'b1;
          // An early RLAST from the slave still terminates the burst.
          if (RLAST || last_beat) begin
            cnt_d   = '0;
            state_d = ST_FIN;
          end else begin
            cnt_d = cnt_q + 9'd1;
          end
        end
      end
      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign err      = err_q;

  assign AWID     = id_q;
  assign AWADDR   = addr_q;
  assign AWLEN    = len_m1_q;
  assign AWSIZE   = AX_SIZE;
  assign AWBURST  = BURST_INCR;
  assign AWLOCK   = 1'b0;
  assign AWCACHE  = 4'd0;
  assign AWPROT   = 3'd0;
  assign AWQOS    = 4'd0;
  assign AWREGION = 4'd0;

  assign ARID     = id_q;
  assign ARADDR   = addr_q;
  assign ARLEN    = len_m1_q;
  assign ARSIZE   = AX_SIZE;
  assign ARBURST  = BURST_INCR;
  assign ARLOCK   = 1'b0;
  assign ARCACHE  = 4'd0;
  assign ARPROT   = 3'd0;
  assign ARQOS    = 4'd0;
  assign ARREGION = 4'd0;

  assign WDATA    = s_wdata;
  assign WSTRB    = '1;
  assign m_rdata  = RDATA;

endmodule

// File: tb/tb_conv_axi_burst_master.sv
// Directed bench for conv_axi_burst_master: table of bursts against a behavioural
// AXI slave and stream endpoints, plus zero-length and mid-burst reset sequences.
module tb_conv_axi_burst_master;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr;
  logic [8:0]  cmd_len;
  logic [9:0]  cmd_id;
  logic [31:0] s_wdata;
  logic        s_wvalid, s_wready;
  logic [31:0] m_rdata;
  logic        m_rvalid, m_rready, m_rlast;
  logic        done, err;
  logic [9:0]  AWID, ARID, BID, RID;
  logic [15:0] AWADDR, ARADDR;
  logic [7:0]  AWLEN, ARLEN;
  logic [2:0]  AWSIZE, ARSIZE, AWPROT, ARPROT, BRESP, RRESP;
  logic [1:0]  AWBURST, ARBURST;
  logic        AWLOCK, ARLOCK;
  logic [3:0]  AWCACHE, ARCACHE, AWQOS, ARQOS, AWREGION, ARREGION;
  logic        AWVALID, AWREADY, ARVALID, ARREADY;
  logic [31:0] WDATA, RDATA;
  logic [3:0]  WSTRB;
  logic        WLAST, WVALID, WREADY;
  logic        BVALID, BREADY;
  logic        RLAST, RVALID, RREADY;

  conv_axi_burst_master dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
    .s_wdata(s_wdata), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rlast(m_rlast),
    .done(done), .err(err),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT), .AWQOS(AWQOS),
    .AWREGION(AWREGION), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT), .ARQOS(ARQOS),
    .ARREGION(ARREGION), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
    .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic        write;
    logic [15:0] addr;
    logic [8:0]  len;
    logic [9:0]  id;
    int          wr_mode;
    int          gap;
    int          rr_mode;
    logic [2:0]  bresp;
    int          bad_rid_beat;
    int          early_last_beat;
    bit          bvalid_early;
    int          exp_beats;
    logic        exp_err;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic wr, logic [15:0] a, logic [8:0] l, logic [9:0] id,
                              int wm, int gap, int rr, logic [2:0] br, int bad_rid,
                              int early, bit bearly, int eb, logic ee);
    vec_t v;
    v.write = wr; v.addr = a; v.len = l; v.id = id;
    v.wr_mode = wm; v.gap = gap; v.rr_mode = rr; v.bresp = br;
    v.bad_rid_beat = bad_rid; v.early_last_beat = early; v.bvalid_early = bearly;
    v.exp_beats = eb; v.exp_err = ee;
    return v;
  endfunction

  task automatic idle_inputs();
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0; cmd_id = 0;
    s_wdata = 0; s_wvalid = 0; m_rready = 0;
    AWREADY = 0; WREADY = 0; BID = 0; BRESP = 0; BVALID = 0; ARREADY = 0;
    RID = 0; RDATA = 0; RRESP = 0; RLAST = 0; RVALID = 0;
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 0);
    chk({tag, "_awvalid"},   AWVALID, 0);
    chk({tag, "_wvalid"},    WVALID, 0);
    chk({tag, "_wlast"},     WLAST, 0);
    chk({tag, "_s_wready"},  s_wready, 0);
    chk({tag, "_bready"},    BREADY, 0);
    chk({tag, "_arvalid"},   ARVALID, 0);
    chk({tag, "_rready"},    RREADY, 0);
    chk({tag, "_m_rvalid"},  m_rvalid, 0);
    chk({tag, "_m_rlast"},   m_rlast, 0);
    chk({tag, "_done"},      done, 0);
    chk({tag, "_err"},       err, 0);
    chk({tag, "_awlen"},     AWLEN, 0);
    chk({tag, "_awaddr"},    AWADDR, 0);
    chk({tag, "_awid"},      AWID, 0);
    chk({tag, "_arlen"},     ARLEN, 0);
  endtask

  task automatic run_vec(input vec_t v, input int abort_beat, output bit aborted);
    int wbeat = 0, src = 0, rbeat = 0, hs_cyc = -10;
    int done_cnt = 0, data_err = 0, last_err = 0, stall_err = 0;
    int bready_early = 0, wrong_ch = 0;
    bit ax_hs = 0, w_done = 0, b_done = 0, r_done = 0, done_ok = 0;
    logic [7:0]  ax_len = 0;
    logic [15:0] ax_addr = 0;
    logic [9:0]  ax_id = 0;
    logic [2:0]  ax_size = 0;
    logic [1:0]  ax_burst = 0;
    logic        err_at_done = 0;
    logic        exp_rlast;
    aborted = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge ACLK); #1;
      cmd_valid = (cyc == 0);
      cmd_write = v.write; cmd_addr = v.addr; cmd_len = v.len; cmd_id = v.id;
      AWREADY  = (cyc >= 2);
      ARREADY  = (cyc >= 2);
      WREADY   = (v.wr_mode != 0) ? (cyc % 2 == 1) : 1'b1;
      s_wvalid = !w_done && ((v.gap != 0) ? (cyc % 3 != 0) : 1'b1);
      s_wdata  = 32'hA000_0000 + src;
      BVALID   = !b_done && (v.bvalid_early ? ax_hs : w_done);
      BID      = v.id;
      BRESP    = v.bresp;
      RVALID   = !v.write && ax_hs && !r_done && ((v.gap != 0) ? (cyc % 4 != 1) : 1'b1);
      RDATA    = 32'h5000_0000 + rbeat * 3;
      RID      = (rbeat == v.bad_rid_beat) ? 10'd6 : v.id;
      exp_rlast = (rbeat == v.len - 1) || (rbeat == v.early_last_beat);
      RLAST    = exp_rlast;
      RRESP    = 0;
      m_rready = (v.rr_mode != 0) ? (cyc % 3 != 2) : 1'b1;
      #1;
      if (cyc == 0) chk("cmd_ready_idle", cmd_ready, 1);
      if (cyc == 1) begin
        chk("axvalid_after_cmd", v.write ? AWVALID : ARVALID, 1);
        chk("err_cleared_on_accept", err, 0);
      end
      if (v.write ? ARVALID : AWVALID) wrong_ch++;
      if (!ax_hs && (v.write ? (AWVALID && AWREADY) : (ARVALID && ARREADY))) begin
        ax_hs    = 1;
        ax_len   = v.write ? AWLEN : ARLEN;
        ax_addr  = v.write ? AWADDR : ARADDR;
        ax_id    = v.write ? AWID : ARID;
        ax_size  = v.write ? AWSIZE : ARSIZE;
        ax_burst = v.write ? AWBURST : ARBURST;
      end
      if (s_wvalid && s_wready) src++;
      if (WVALID && WREADY) begin
        if (abort_beat >= 0 && wbeat == abort_beat) begin
          aborted = 1;
          break;
        end
        if (WDATA !== 32'hA000_0000 + wbeat || WSTRB !== 4'hF) data_err++;
        if (WLAST !== (wbeat == v.len - 1)) last_err++;
        if (wbeat == v.len - 1) w_done = 1;
        wbeat++;
      end
      if (BREADY && !w_done) bready_early++;
      if (BVALID && BREADY && !b_done) begin
        b_done = 1;
        hs_cyc = cyc;
      end
      if (!m_rready && RREADY) stall_err++;
      if (RVALID && RREADY && !r_done) begin
        if (m_rvalid !== 1'b1 || m_rdata !== 32'h5000_0000 + rbeat * 3) data_err++;
        if (m_rlast !== exp_rlast) last_err++;
        if (exp_rlast) begin
          r_done = 1;
          hs_cyc = cyc;
        end
        rbeat++;
      end
      if (done) begin
        done_cnt++;
        if (cyc == hs_cyc + 1) done_ok = 1;
        err_at_done = err;
      end
      if (done_cnt > 0 && cyc >= hs_cyc + 3) break;
    end
    if (!aborted) begin
      chk("ax_handshake", ax_hs, 1);
      chk("axlen", ax_len, 8'(v.len - 9'd1));
      chk("axaddr", ax_addr, v.addr);
      chk("axid", ax_id, v.id);
      chk("axsize", ax_size, 3'b010);
      chk("axburst", ax_burst, 2'b01);
      chk("beats", v.write ? wbeat : rbeat, v.exp_beats);
      chk("data_order_errs", data_err, 0);
      chk("last_flag_errs", last_err, 0);
      chk("rready_stall_errs", stall_err, 0);
      chk("bready_before_b", bready_early, 0);
      chk("other_channel_valid", wrong_ch, 0);
      chk("done_pulses", done_cnt, 1);
      chk("done_latency", done_ok, 1);
      chk("err_at_done", err_at_done, v.exp_err);
    end
  endtask

  vec_t vecs[9];
  vec_t v;
  bit   ab;
  int   reset_done_seen;

  initial begin
    vecs[0] = mk(1, 16'd160,  9'd256, 10'd0, 0, 0, 0, 3'b000, -1, -1, 0, 256, 0);
    vecs[1] = mk(1, 16'd0,    9'd38,  10'd1, 1, 1, 0, 3'b000, -1, -1, 1,  38, 0);
    vecs[2] = mk(0, 16'd1280, 9'd196, 10'd5, 0, 0, 1, 3'b000, -1, -1, 0, 196, 0);
    vecs[3] = mk(1, 16'd64,   9'd4,   10'd2, 0, 0, 0, 3'b010, -1, -1, 0,   4, 1);
    vecs[4] = mk(0, 16'd512,  9'd20,  10'd5, 0, 1, 0, 3'b000, 10, -1, 0,  20, 1);
    vecs[5] = mk(0, 16'd768,  9'd196, 10'd7, 0, 0, 1, 3'b000, -1, 99, 0, 100, 1);
    vecs[6] = mk(1, 16'd4,    9'd1,   10'd9, 0, 0, 0, 3'b000, -1, -1, 0,   1, 0);
    vecs[7] = mk(1, 16'd8,    9'd2,   10'd3, 1, 0, 0, 3'b001, -1, -1, 0,   2, 1);
    vecs[8] = mk(0, 16'd12,   9'd1,   10'd4, 0, 0, 0, 3'b000, -1, -1, 0,   1, 0);

    idle_inputs();
    ARESETn = 0;
    repeat (3) @(posedge ACLK);
    #1;
    check_reset_outs("por");
    ARESETn = 1;
    @(posedge ACLK); #1;
    chk("cmd_ready_after_reset", cmd_ready, 1);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], -1, ab);

    // zero-length command: straight to done with err, no address phase
    @(posedge ACLK); #1;
    idle_inputs();
    cmd_valid = 1; cmd_write = 1; cmd_len = 0; cmd_id = 10'd3;
    #1;
    chk("zl_cmd_ready", cmd_ready, 1);
    @(posedge ACLK); #1;
    cmd_valid = 0;
    #1;
    chk("zl_done", done, 1);
    chk("zl_err", err, 1);
    chk("zl_awvalid", AWVALID, 0);
    chk("zl_arvalid", ARVALID, 0);
    @(posedge ACLK); #2;
    chk("zl_done_single", done, 0);
    chk("zl_awvalid_after", AWVALID, 0);

    // reset during beat 100 of a 256-beat write
    v = vecs[0];
    run_vec(v, 100, ab);
    chk("abort_reached", ab, 1);
    ARESETn = 0;
    #1;
    check_reset_outs("mid");
    reset_done_seen = 0;
    repeat (3) begin
      @(posedge ACLK); #1;
      if (done) reset_done_seen++;
    end
    chk("no_done_in_reset", reset_done_seen, 0);
    ARESETn = 1;
    @(posedge ACLK); #1;
    if (done) reset_done_seen++;
    chk("no_done_after_reset", reset_done_seen, 0);
    run_vec(vecs[3], -1, ab);
    run_vec(vecs[6], -1, ab);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
